// File: rtl/segre_icache_refill_unit_if.sv
// Fetch-stage and memory-side signal bundle for the icache refill unit.
// The slave modport is the refill unit; the master modport is its environment.
interface segre_icache_refill_unit_if #(
  parameter int unsigned ADDR_SIZE         = 32,
  parameter int unsigned ICACHE_LANE_SIZE  = 128,
  parameter int unsigned ICACHE_INDEX_SIZE = 2
);
  logic                         ic_access_i;
  logic                         ic_miss_i;
  logic [ADDR_SIZE-1:0]         ic_addr_i;
  logic                         mmu_data_o;
  logic [ICACHE_LANE_SIZE-1:0]  mmu_wr_data_o;
  logic [ICACHE_INDEX_SIZE-1:0] mmu_lru_index_o;
  logic                         mem_rd_o;
  logic [ADDR_SIZE-1:0]         mem_addr_o;
  logic [ICACHE_LANE_SIZE-1:0]  mem_rd_data_i;
  logic                         mem_ready_i;

  modport slave (
    input  ic_access_i, ic_miss_i, ic_addr_i, mem_rd_data_i, mem_ready_i,
    output mmu_data_o, mmu_wr_data_o, mmu_lru_index_o, mem_rd_o, mem_addr_o
  );

  modport master (
    output ic_access_i, ic_miss_i, ic_addr_i, mem_rd_data_i, mem_ready_i,
    input  mmu_data_o, mmu_wr_data_o, mmu_lru_index_o, mem_rd_o, mem_addr_o
  );
endinterface

// File: rtl/segre_icache_refill_unit.sv
// Instruction-cache miss responder: fetches a line from memory, returns it with
// the victim index, and keeps per-line LRU ages updated on hits and refills.
module segre_icache_refill_unit #(
  parameter int unsigned ADDR_SIZE         = 32,
  parameter int unsigned ICACHE_LANE_SIZE  = 128,
  parameter int unsigned ICACHE_INDEX_SIZE = 2,
  parameter int unsigned ICACHE_BYTE_SIZE  = 4
) (
  input logic clk_i,
  input logic rst_i,
  segre_icache_refill_unit_if.slave bus_if
);

  localparam int unsigned ICACHE_LINES = 2 ** ICACHE_INDEX_SIZE;
  localparam logic [ADDR_SIZE-1:0] OFFSET_MASK =
    ADDR_SIZE'((64'd1 << ICACHE_BYTE_SIZE) - 64'd1);

  typedef enum logic [1:0] {RF_IDLE, RF_WAIT, RF_RESP} rf_state_e;

  rf_state_e                    state_q, state_d;
  logic [ADDR_SIZE-1:0]         addr_q, addr_d;
  logic [ICACHE_INDEX_SIZE-1:0] victim_q, victim_d;
  logic [ICACHE_LANE_SIZE-1:0]  line_q, line_d;
  logic                         mem_rd_q, mem_rd_d;
  logic [ADDR_SIZE-1:0]         mem_addr_q, mem_addr_d;
  logic                         mmu_data_q, mmu_data_d;
  logic [ICACHE_INDEX_SIZE-1:0] age_q [ICACHE_LINES];
  logic [ICACHE_INDEX_SIZE-1:0] age_d [ICACHE_LINES];
  logic                         touch_en;
  logic [ICACHE_INDEX_SIZE-1:0] touch_idx;
  logic [ICACHE_INDEX_SIZE-1:0] lru_idx;

  // LRU line is the one holding the oldest age.
  always_comb begin
    lru_idx = '0;
    for (int unsigned i = 0; i < ICACHE_LINES; i++) begin
      if (age_q[i] == ICACHE_INDEX_SIZE'(ICACHE_LINES - 1)) begin
        lru_idx = ICACHE_INDEX_SIZE'(i);
      end
    end
  end

  // Touch: younger lines age by one, the touched line becomes youngest.
  always_comb begin
    for (int unsigned i = 0; i < ICACHE_LINES; i++) begin
      age_d[i] = age_q[i];
      if (touch_en) begin
        if (ICACHE_INDEX_SIZE'(i) == touch_idx) begin
          age_d[i] = '0;
        end else if (age_q[i] < age_q[touch_idx]) begin
          age_d[i] = age_q[i] + ICACHE_INDEX_SIZE'(1);
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    victim_d   = victim_q;
    line_d     = line_q;
    mem_rd_d   = 1'b0;
    mem_addr_d = '0;
    mmu_data_d = 1'b0;
    touch_en   = 1'b0;
    touch_idx  = '0;
    unique case (state_q)
      RF_IDLE: begin
        if (bus_if.ic_access_i && bus_if.ic_miss_i) begin
          addr_d     = bus_if.ic_addr_i & ~OFFSET_MASK;
          victim_d   = lru_idx;
          state_d    = RF_WAIT;
          mem_rd_d   = 1'b1;
          mem_addr_d = bus_if.ic_addr_i & ~OFFSET_MASK;
        end else if (bus_if.ic_access_i) begin
          touch_en  = 1'b1;
          touch_idx = bus_if.ic_addr_i[ICACHE_INDEX_SIZE-1:0];
        end
      end
      RF_WAIT: begin
        if (bus_if.mem_ready_i) begin
          line_d     = bus_if.mem_rd_data_i;
          state_d    = RF_RESP;
          mmu_data_d = 1'b1;
        end else begin
          mem_rd_d   = 1'b1;
          mem_addr_d = addr_q;
        end
      end
      RF_RESP: begin
        touch_en  = 1'b1;
        touch_idx = victim_q;
        state_d   = RF_IDLE;
      end
      default: state_d = RF_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= RF_IDLE;
      addr_q     <= '0;
      victim_q   <= '0;
      line_q     <= '0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      mmu_data_q <= 1'b0;
      for (int unsigned i = 0; i < ICACHE_LINES; i++) begin
        age_q[i] <= ICACHE_INDEX_SIZE'(ICACHE_LINES - 1 - i);
      end
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      victim_q   <= victim_d;
      line_q     <= line_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      mmu_data_q <= mmu_data_d;
      for (int unsigned i = 0; i < ICACHE_LINES; i++) begin
        age_q[i] <= age_d[i];
      end
    end
  end

  // Victim index is live from the ages except while a refill is being returned.
  assign bus_if.mmu_lru_index_o = (state_q == RF_RESP) ? victim_q : lru_idx;
  assign bus_if.mmu_data_o      = mmu_data_q;
  assign bus_if.mmu_wr_data_o   = line_q;
  assign bus_if.mem_rd_o        = mem_rd_q;
  assign bus_if.mem_addr_o      = mem_addr_q;

endmodule
